it_exec_ctrl: RTL

Parametrised IT-block execution controller for the Thumb-2 front end. It sits between the pre-decoder and the xPSR register. It holds ITSTATE, evaluates each issued instruction's condition against APSR, and flags instructions that must be converted to hints (skipped). It generalises the single-issue IT/condition logic to LANES instructions per cycle and adds stall, flush, ITSTATE restore and nested-IT error reporting.

---
 rtl/it_exec_ctrl_pkg.sv | 55 +++++
 rtl/it_exec_ctrl_if.sv | 32 +++
 rtl/it_exec_ctrl_cond_eval.sv | 12 +
 rtl/it_exec_ctrl.sv | 72 +++++++
 4 files changed

// File: rtl/it_exec_ctrl_pkg.sv
// Shared definitions for the IT-block execution controller: condition codes,
// ITSTATE width and the ITSTATE advance / condition evaluation helpers.
package it_pkg;

    localparam int ITSTATE_W = 8;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    // The slot whose state has [2:0]==000 is the last one of the block.
    function automatic logic [ITSTATE_W-1:0] it_advance(input logic [ITSTATE_W-1:0] itstate);
        logic [ITSTATE_W-1:0] nxt;
        if (itstate[2:0] == 3'b000) nxt = '0;
        else                        nxt = {itstate[7:5], itstate[3:0], 1'b0};
        return nxt;
    endfunction

    // apsr = {N, Z, C, V, Q}; Q never takes part in a condition.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [4:0] apsr);
        logic n, z, c, v, p;
        {n, z, c, v} = apsr[4:1];
        case (cond)
            COND_EQ: p = z;
            COND_NE: p = !z;
            COND_CS: p = c;
            COND_CC: p = !c;
            COND_MI: p = n;
            COND_PL: p = !n;
            COND_VS: p = v;
            COND_VC: p = !v;
            COND_HI: p = c && !z;
            COND_LS: p = !c || z;
            COND_GE: p = (n == v);
            COND_LT: p = (n != v);
            COND_GT: p = !z && (n == v);
            COND_LE: p = z || (n != v);
            default: p = 1'b1;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/it_exec_ctrl_if.sv
// Pre-decoder / xPSR side bundle of the IT execution controller.
// master = issuing front end, slave = it_exec_ctrl.
interface it_exec_ctrl_if #(
    parameter int LANES = 1
);
    import it_pkg::*;

    logic [4:0]           apsr;
    logic [LANES-1:0]     inst_valid;
    logic [LANES-1:0]     inst_is_it;
    logic [8*LANES-1:0]   it_field;
    logic                 stall;
    logic                 flush;
    logic                 itstate_ld;
    logic [ITSTATE_W-1:0] itstate_in;
    logic [ITSTATE_W-1:0] itstate;
    logic                 in_it_blk;
    logic [4*LANES-1:0]   cur_cond;
    logic [LANES-1:0]     skip;
    logic                 it_err;

    modport master (
        output apsr, inst_valid, inst_is_it, it_field, stall, flush, itstate_ld, itstate_in,
        input  itstate, in_it_blk, cur_cond, skip, it_err
    );

    modport slave (
        input  apsr, inst_valid, inst_is_it, it_field, stall, flush, itstate_ld, itstate_in,
        output itstate, in_it_blk, cur_cond, skip, it_err
    );

endinterface

// File: rtl/it_exec_ctrl_cond_eval.sv
// Combinational condition-code check of one lane against the APSR flags.
module it_cond_eval
    import it_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] apsr,
    output logic       pass
);

    assign pass = cond_pass(cond, apsr);

endmodule

// File: rtl/it_exec_ctrl.sv
// IT-block execution controller: holds ITSTATE, walks it across LANES issue
// slots per cycle and flags instructions whose condition fails.
module it_exec_ctrl
    import it_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic          clk,
    input  logic          rst,
    it_exec_ctrl_if.slave bus
);

    logic [ITSTATE_W-1:0] state_q;
    logic [ITSTATE_W-1:0] state_nxt;
    logic [ITSTATE_W-1:0] lane_s;
    logic [3:0]           lane_fc;
    logic [3:0]           lane_mask;
    logic [4*LANES-1:0]   cond_all;
    logic [LANES-1:0]     pass_lane;
    logic                 err_any;

    // Lane k sees the state left behind by lanes 0..k-1 of this same cycle.
    always_comb begin
        lane_s    = state_q;
        lane_fc   = '0;
        lane_mask = '0;
        err_any   = 1'b0;
        cond_all  = {LANES{COND_AL}};
        for (int k = 0; k < LANES; k++) begin
            lane_fc   = bus.it_field[8*k+4 +: 4];
            lane_mask = bus.it_field[8*k +: 4];
            cond_all[4*k +: 4] = (lane_s[3:0] != 4'b0000) ? lane_s[7:4] : COND_AL;
            if (bus.inst_valid[k]) begin
                if (bus.inst_is_it[k] && (lane_s[3:0] == 4'b0000)) begin
                    if (lane_mask == 4'b0000) begin
                        err_any = 1'b1;
                        lane_s  = '0;
                    end else begin
                        lane_s = {(lane_fc == 4'hF) ? COND_AL : lane_fc, lane_mask};
                    end
                end else begin
                    // A nested IT is consumed as an ordinary conditional slot.
                    if (bus.inst_is_it[k]) err_any = 1'b1;
                    lane_s = it_advance(lane_s);
                end
            end
        end
        state_nxt = lane_s;
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        it_cond_eval u_cond_eval (
            .cond (cond_all[4*k +: 4]),
            .apsr (bus.apsr),
            .pass (pass_lane[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst)                state_q <= '0;
        else if (bus.flush)      state_q <= '0;
        else if (bus.itstate_ld) state_q <= bus.itstate_in;
        else if (!bus.stall)     state_q <= state_nxt;
    end

    assign bus.itstate   = state_q;
    assign bus.in_it_blk = |state_q[3:0];
    assign bus.cur_cond  = cond_all;
    assign bus.skip      = bus.inst_valid & ~pass_lane;
    assign bus.it_err    = err_any & ~bus.stall & ~bus.flush;

endmodule
